div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider for the OpenMIPS core, operating beside the EX stage. It accepts operands and a start request from EX. It computes quotient and remainder by restoring shift-subtract, one bit per cycle. It returns a 64-bit result with a ready flag, which EX forwards into the HI/LO write path (HI = remainder, LO = quotient) while the pipeline is stalled.

## Interface
Parameters:
- none (width fixed at 32 by `RegBus`)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request; EX holds it high until ready_o seen
- annul_i  input  1  abort current division (pipeline flush)
- result_o  output  64  {remainder[31:0], quotient[31:0]}, registered
- ready_o  output  1  result valid, registered

## Operation
- States: FREE, BY_ZERO, ON, END. Reset → FREE, cnt=0, dividend reg=0, result_o=0, ready_o=0.
- FREE:
  - start_i=1 and annul_i=0 with opdata2_i==0 → BY_ZERO.
  - start_i=1 and annul_i=0 with opdata2_i≠0 → ON:
    - cnt=0.
    - Latch divisor = |opdata2_i| when signed, else opdata2_i.
    - Load 65-bit dividend reg = {32'b0, |opdata1_i| or opdata1_i, 1'b0}.
    - Latch both operand signs.
  - Otherwise stay; result_o=0, ready_o=0.
- BY_ZERO: next edge → END with result_o=64'b0, ready_o=1.
- ON, annul_i=1: → FREE, cnt=0, ready_o stays 0. Annul has priority over the iteration.
- ON, cnt<32: one iteration per cycle.
  - diff = {1'b0, dividend[63:32]} − {1'b0, divisor} (33-bit).
  - diff[32]=1 → dividend <= {dividend[63:0], 1'b0}.
  - diff[32]=0 → dividend <= {diff[31:0], dividend[31:0], 1'b1}.
  - cnt++.
- ON, cnt==32: quotient = dividend[31:0], remainder = dividend[64:33].
  - Signed: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Remainder takes the dividend's sign, quotient truncates toward zero.
  - Latch result_o = {remainder, quotient}, ready_o=1, → END.
- END: hold result_o and ready_o while start_i=1. start_i=0 → FREE, result_o=0, ready_o=0 on that edge.
- The pipeline stalls during the operation, so operands are sampled only on entry to ON. Later changes on opdata*_i are ignored.
- start_i dropping while in ON does not abort; only annul_i or rst aborts.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).

## Timing
- start_i first high in cycle 0:
  - ON entered at edge 1.
  - Iterations on edges 2–33.
  - END entered at edge 34.
  - ready_o high from cycle 34.
  - Latency 34 cycles.
- Divide by zero: BY_ZERO at edge 1, ready_o high from cycle 2.
- After start_i falls in END, ready_o is low the next cycle. A new start is accepted one cycle after FREE is re-entered, so the minimum back-to-back spacing is 36 cycles.
- rst=1 at any edge overrides every state, including mid-ON and END. All outputs are 0 the following cycle.
- annul_i is sampled only in FREE (blocks acceptance) and ON (aborts). It is ignored in BY_ZERO and END.

## Configuration
- `DIV_SIGNED_EN` defined: signed path active as above (operand absolute values, sign correction on exit).
- Not defined: signed_div_i is ignored and every operation is unsigned. The sign-correction logic and the absolute-value negators are not synthesized.

## Test plan
- Unsigned 100 / 7: signed_div_i=0, start cycle 0 → ready_o=1 at cycle 34, result_o=64'h00000002_0000000E; held until start_i drops, then 0.
- Signed −7 / 2 (0xFFFFFFF9 / 2), `DIV_SIGNED_EN` set → result_o=64'hFFFFFFFF_FFFFFFFD. Same stimulus with the macro unset → 64'h00000001_7FFFFFFC.
- Divide by zero: 0x1234 / 0 → ready_o=1 at cycle 2, result_o=0.
- Annul at cycle 10 of an ON run:
  - FREE at cycle 11; ready_o never asserts.
  - A new start in cycle 12 (5 / 5) gives result 64'h00000000_00000001 at cycle 46.
- rst=1 at cycle 20 mid-division → cycle 21 state FREE, ready_o=0, result_o=0. A fresh request completes normally.
- Signed edge cases:
  - 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
  - 0xFFFFFFFF / 1 unsigned → 64'h00000000_FFFFFFFF.

Source files
------------

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- multi-cycle 32-bit integer divider for the OpenMIPS EX stage.
//
// Computes quotient and remainder by restoring shift-subtract, one quotient
// bit per clock. EX holds start_i high and stalls the pipeline until ready_o
// is seen. EX then writes result_o into HI/LO (HI = remainder, LO = quotient).
//
// Ports:
//   clk           core clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request, held high by EX until ready_o
//   annul_i       abort the current division (pipeline flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// Configuration macro:
//   DIV_SIGNED_EN  when defined, signed_div_i selects signed division.
//                  Operands are converted to magnitudes on entry and the
//                  signs are corrected on exit. When undefined, every
//                  operation is unsigned and the sign logic is not built.
// -----------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } divState_e;

  divState_e   state_q;
  logic [5:0]  cnt_q;
  logic [64:0] dividend_q;
  logic [31:0] divisor_q;
  logic [63:0] result_q;
  logic        ready_q;

  // Operand magnitudes that are loaded into the datapath on entry to ON
  logic [31:0] op1Mag;
  logic [31:0] op2Mag;

  // Quotient and remainder after any sign correction
  logic [31:0] quotientFinal;
  logic [31:0] remainderFinal;

  // Trial subtraction and the shifted working register for one iteration
  logic [32:0] diff;
  logic [64:0] dividend_d;

`ifdef DIV_SIGNED_EN
  logic signedOp;
  logic dividendNeg_q;
  logic divisorNeg_q;

  assign signedOp = signed_div_i;

  // Two's-complement magnitude of each operand for a signed request.
  // 0x80000000 maps onto itself, and that is the correct unsigned magnitude.
  always_comb begin
    op1Mag = opdata1_i;
    op2Mag = opdata2_i;
    if (signedOp && opdata1_i[31]) begin
      op1Mag = ~opdata1_i + 32'd1;
    end
    if (signedOp && opdata2_i[31]) begin
      op2Mag = ~opdata2_i + 32'd1;
    end
  end

  // The quotient truncates toward zero, so it is negated when the operand
  // signs differ. The remainder follows the sign of the dividend. The
  // overflow case 0x80000000 / -1 wraps to 0x80000000 without a trap.
  always_comb begin
    quotientFinal  = dividend_q[31:0];
    remainderFinal = dividend_q[64:33];
    if (dividendNeg_q ^ divisorNeg_q) begin
      quotientFinal = ~dividend_q[31:0] + 32'd1;
    end
    if (dividendNeg_q) begin
      remainderFinal = ~dividend_q[64:33] + 32'd1;
    end
  end
`else
  logic unusedSignedDiv;

  // Every operation is unsigned in this build, so the operands pass straight
  // through and signed_div_i has no effect.
  assign unusedSignedDiv = signed_div_i;

  always_comb begin
    op1Mag         = opdata1_i;
    op2Mag         = opdata2_i;
    quotientFinal  = dividend_q[31:0];
    remainderFinal = dividend_q[64:33];
  end
`endif

  // Restoring step. The partial remainder sits in dividend_q[63:32].
  // On a borrow, only shift in a 0 quotient bit. Otherwise keep the
  // difference and shift in a 1. After 32 steps the quotient is in
  // [31:0] and the remainder is in [64:33].
  always_comb begin
    diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    if (diff[32]) begin
      dividend_d = {dividend_q[63:0], 1'b0};
    end else begin
      dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
    end
  end

  // Controller and datapath registers. Operands are sampled only on entry
  // to ON because the pipeline is stalled for the whole operation. A drop of
  // start_i during ON does not abort; only annul_i or rst does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FREE;
      cnt_q         <= 6'd0;
      dividend_q    <= 65'd0;
      divisor_q     <= 32'd0;
      result_q      <= 64'd0;
      ready_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      dividendNeg_q <= 1'b0;
      divisorNeg_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        FREE: begin
          result_q <= 64'd0;
          ready_q  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= BY_ZERO;
            end else begin
              state_q       <= ON;
              cnt_q         <= 6'd0;
              divisor_q     <= op2Mag;
              dividend_q    <= {32'd0, op1Mag, 1'b0};
`ifdef DIV_SIGNED_EN
              dividendNeg_q <= signedOp & opdata1_i[31];
              divisorNeg_q  <= signedOp & opdata2_i[31];
`endif
            end
          end
        end

        BY_ZERO: begin
          state_q  <= END;
          result_q <= 64'd0;
          ready_q  <= 1'b1;
        end

        ON: begin
          if (annul_i) begin
            state_q <= FREE;
            cnt_q   <= 6'd0;
            ready_q <= 1'b0;
          end else if (cnt_q != 6'd32) begin
            dividend_q <= dividend_d;
            cnt_q      <= cnt_q + 6'd1;
          end else begin
            result_q <= {remainderFinal, quotientFinal};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end

        END: begin
          if (!start_i) begin
            state_q  <= FREE;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= FREE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed testbench for div: a table of divisions with hand-computed
// results, plus hand-written sequences for annul, reset and early start drop.
module tb_div;

   typedef struct {
      string       name;
      logic        signedDiv;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [63:0] expResult;
      int          expLatency;
   } divVector_t;

   logic        clk;
   logic        rst;
   logic        signedDiv;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int testsRun;
   int testsFailed;

   divVector_t vectors[10];

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signedDiv),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and log a failure line when it differs
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Advance one clock and land on the following falling edge
   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run one complete division: latency, result, hold while start stays
   // high, then clear once start drops. The operands are scrambled
   // mid-run, and the divider must ignore that change.
   task automatic applyStimulus(input divVector_t v);
      int latency;
      logic [63:0] held;
      @(negedge clk);
      signedDiv = v.signedDiv;
      opdata1   = v.op1;
      opdata2   = v.op2;
      annul     = 1'b0;
      start     = 1'b1;
      latency   = 0;
      while (!ready && latency < 100) begin
         nextCycle();
         latency++;
         if (latency == 3) begin
            opdata1 = ~v.op1;
            opdata2 = v.op2 ^ 32'h5A5A_0001;
         end
      end
      checkOutput({v.name, " latency"}, 64'(latency), 64'(v.expLatency));
      checkOutput({v.name, " result"}, result, v.expResult);
      held = result;
      nextCycle();
      checkOutput({v.name, " ready held"}, {63'd0, ready}, 64'd1);
      checkOutput({v.name, " result held"}, result, held);
      start = 1'b0;
      nextCycle();
      checkOutput({v.name, " ready cleared"}, {63'd0, ready}, 64'd0);
      checkOutput({v.name, " result cleared"}, result, 64'd0);
   endtask

   initial begin
      int firstReady;

      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      signedDiv   = 1'b0;
      opdata1     = 32'd0;
      opdata2     = 32'd0;
      start       = 1'b0;
      annul       = 1'b0;

      vectors[0] = '{"u100div7",  1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 34};
      vectors[1] = '{"divzero",   1'b0, 32'h0000_1234, 32'd0,        64'h0,                 2};
      vectors[2] = '{"uffffdiv1", 1'b0, 32'hFFFF_FFFF, 32'd1,        64'h00000000_FFFFFFFF, 34};
      vectors[3] = '{"uffffdivf", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001, 34};
      vectors[4] = '{"u12345678", 1'b0, 32'd12345678,  32'd1000,     64'h000002A6_00003039, 34};
      vectors[5] = '{"u3div10",   1'b0, 32'd3,         32'd10,       64'h00000003_00000000, 34};
`ifdef DIV_SIGNED_EN
      vectors[6] = '{"sm7div2",   1'b1, 32'hFFFF_FFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34};
      vectors[7] = '{"soverflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34};
      vectors[8] = '{"s7divm2",   1'b1, 32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34};
      vectors[9] = '{"sm100m7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 34};
`else
      vectors[6] = '{"sm7div2",   1'b1, 32'hFFFF_FFF9, 32'd2,        64'h00000001_7FFFFFFC, 34};
      vectors[7] = '{"soverflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 34};
      vectors[8] = '{"s7divm2",   1'b1, 32'd7,         32'hFFFF_FFFE, 64'h00000007_00000000, 34};
      vectors[9] = '{"sm100m7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFF9C_00000000, 34};
`endif

      // Reset state
      repeat (3) nextCycle();
      checkOutput("reset ready", {63'd0, ready}, 64'd0);
      checkOutput("reset result", result, 64'd0);
      rst = 1'b0;
      nextCycle();

      // Table-driven divisions
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vectors[i]);
      end

      // Annul in cycle 10, then a new 5 / 5 request in cycle 12
      nextCycle();
      signedDiv  = 1'b0;
      opdata1    = 32'd100;
      opdata2    = 32'd7;
      start      = 1'b1;
      firstReady = -1;
      for (int c = 1; c <= 80 && firstReady < 0; c++) begin
         nextCycle();
         if (ready) firstReady = c;
         if (c == 10) begin
            annul = 1'b1;
            start = 1'b0;
         end
         if (c == 11) annul = 1'b0;
         if (c == 12) begin
            opdata1 = 32'd5;
            opdata2 = 32'd5;
            start   = 1'b1;
         end
      end
      checkOutput("annul ready cycle", 64'(firstReady), 64'd46);
      checkOutput("annul new result", result, 64'h00000000_00000001);
      start = 1'b0;
      nextCycle();
      checkOutput("annul ready cleared", {63'd0, ready}, 64'd0);

      // Reset asserted in cycle 20 of a running division
      nextCycle();
      opdata1 = 32'd100;
      opdata2 = 32'd7;
      start   = 1'b1;
      firstReady = -1;
      for (int c = 1; c <= 20; c++) begin
         nextCycle();
         if (ready) firstReady = c;
      end
      rst = 1'b1;
      nextCycle();
      checkOutput("midrun ready before reset", 64'(firstReady), 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("midrun reset ready", {63'd0, ready}, 64'd0);
      checkOutput("midrun reset result", result, 64'd0);
      rst   = 1'b0;
      start = 1'b0;
      nextCycle();
      applyStimulus(vectors[0]);

      // Reset while holding a finished result in END
      applyStimulus(vectors[4]);
      nextCycle();
      opdata1 = 32'd100;
      opdata2 = 32'd7;
      start   = 1'b1;
      for (int c = 1; c <= 35; c++) nextCycle();
      checkOutput("end before reset ready", {63'd0, ready}, 64'd1);
      rst = 1'b1;
      nextCycle();
      checkOutput("end reset ready", {63'd0, ready}, 64'd0);
      checkOutput("end reset result", result, 64'd0);
      rst   = 1'b0;
      start = 1'b0;
      nextCycle();

      // start_i dropping during ON does not abort; ready pulses for one cycle
      signedDiv  = 1'b0;
      opdata1    = 32'd100;
      opdata2    = 32'd7;
      start      = 1'b1;
      firstReady = -1;
      for (int c = 1; c <= 80 && firstReady < 0; c++) begin
         nextCycle();
         if (ready) firstReady = c;
         if (c == 5) start = 1'b0;
      end
      checkOutput("early drop ready cycle", 64'(firstReady), 64'd34);
      checkOutput("early drop result", result, 64'h00000002_0000000E);
      nextCycle();
      checkOutput("early drop ready pulse", {63'd0, ready}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
